ppu_vram_ctrl: RTL and testbench



---
 rtl/ppu_pkg.sv | 18 +
 rtl/ppu_dpram.sv | 20 ++
 rtl/ppu_vram_ctrl.sv | 74 +++++++
 tb/tb_ppu_vram_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types, region map and address helpers for the PPU VRAM responder
package ppu_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} cpu_state_t;
  typedef enum logic [1:0] {REG_CHR, REG_NT, REG_PAL} region_t;
  localparam logic [13:0] CHR_BASE = 14'h0000;
  localparam logic [13:0] NT_BASE  = 14'h2000;
  localparam logic [13:0] PAL_BASE = 14'h3F00;
  function automatic region_t decode(input logic [13:0] a);
    return (a >= PAL_BASE) ? REG_PAL : (a >= NT_BASE) ? REG_NT : REG_CHR;
  endfunction
  // 0x3000-0x3EFF aliases 0x2000-0x2EFF for free since bit 12 is never used
  function automatic logic [10:0] nt_index(input logic [11:0] a, input logic mv);
    return {mv ? a[10] : a[11], a[9:0]};
  endfunction
  function automatic logic [4:0] pal_fold(input logic [4:0] i);
    return (i[1:0] == 2'b00) ? {1'b0, i[3:0]} : i;
  endfunction
endpackage

// File: rtl/ppu_dpram.sv
// ppu_dpram: simple dual-port synchronous RAM, port A read-only, port B read/write
module ppu_dpram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] a_addr_i,
  output logic [DW-1:0] a_rdata_o,
  input  logic [AW-1:0] b_addr_i,
  input  logic          b_we_i,
  input  logic [DW-1:0] b_wdata_i,
  output logic [DW-1:0] b_rdata_o
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    a_rdata_o <= mem[a_addr_i];
    b_rdata_o <= mem[b_addr_i];
    if (b_we_i) mem[b_addr_i] <= b_wdata_i;
  end
endmodule

// File: rtl/ppu_vram_ctrl.sv
// ppu_vram_ctrl: PPU VRAM responder serving render fetches and the CPU PPUDATA port
module ppu_vram_ctrl
  import ppu_pkg::*;
#(
  parameter int CHR_AW = 13,
  parameter int NT_AW  = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] VRAM_addr,
  output logic [7:0]  VRAM_data_out,
  input  logic        render_active,
  input  logic        mirror_v,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata
);
  cpu_state_t state_q, state_d;
  region_t    rreg_q, creg;
  logic [7:0] buf_q, buf_d, vram_q, vram_d;
  logic [7:0] chr_a, chr_b, nt_a, nt_b;
  logic [5:0] pal_a, pal_b;
  logic       acc_we, resp;
  logic       unused_addr;
  assign unused_addr = ^VRAM_addr[15:14];
  assign creg   = decode(cpu_addr);
  assign acc_we = (state_q == ACCESS) && cpu_we;
  ppu_dpram #(.AW(CHR_AW), .DW(8)) u_chr (
    .clk(clk),
    .a_addr_i(CHR_AW'(VRAM_addr[13:0] - CHR_BASE)), .a_rdata_o(chr_a),
    .b_addr_i(CHR_AW'(cpu_addr - CHR_BASE)), .b_we_i(acc_we && creg == REG_CHR),
    .b_wdata_i(cpu_wdata), .b_rdata_o(chr_b)
  );
  // A palette read also fetches the shadowed nametable byte: 0x3Fxx and 0x2Fxx share bits 11:0
  ppu_dpram #(.AW(NT_AW), .DW(8)) u_nt (
    .clk(clk),
    .a_addr_i(NT_AW'(nt_index(VRAM_addr[11:0], mirror_v))), .a_rdata_o(nt_a),
    .b_addr_i(NT_AW'(nt_index(cpu_addr[11:0], mirror_v))), .b_we_i(acc_we && creg == REG_NT),
    .b_wdata_i(cpu_wdata), .b_rdata_o(nt_b)
  );
  ppu_dpram #(.AW(5), .DW(6)) u_pal (
    .clk(clk),
    .a_addr_i(pal_fold(VRAM_addr[4:0])), .a_rdata_o(pal_a),
    .b_addr_i(pal_fold(cpu_addr[4:0])), .b_we_i(acc_we && creg == REG_PAL),
    .b_wdata_i(cpu_wdata[5:0]), .b_rdata_o(pal_b)
  );
  always_comb begin
    state_d   = state_q;
    resp      = state_q == RESP;
    state_d   = (state_q == IDLE) ? ((cpu_req && !render_active) ? ACCESS : IDLE) :
                (state_q == ACCESS) ? RESP : IDLE;
    cpu_ack   = resp;
    cpu_rdata = !resp ? 8'h00 : (creg == REG_PAL) ? {2'b00, pal_b} : buf_q;
    buf_d     = (resp && !cpu_we) ? ((creg == REG_CHR) ? chr_b : nt_b) : buf_q;
    vram_d    = (rreg_q == REG_CHR) ? chr_a : (rreg_q == REG_NT) ? nt_a : {2'b00, pal_a};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      buf_q   <= 8'h00;
      vram_q  <= 8'h00;
      rreg_q  <= REG_CHR;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      vram_q  <= vram_d;
      rreg_q  <= decode(VRAM_addr[13:0]);
    end
  end
  assign VRAM_data_out = vram_q;
endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// tb_ppu_vram_ctrl: directed vector table plus hand sequences for stall, mid-access and reset
module tb_ppu_vram_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] VRAM_addr = 16'h0000;
  logic [7:0]  VRAM_data_out;
  logic        render_active = 1'b0;
  logic        mirror_v = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [13:0] cpu_addr = 14'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  int n_chk = 0;
  int n_fail = 0;
  ppu_vram_ctrl dut (
    .clk(clk), .reset_n(reset_n), .VRAM_addr(VRAM_addr), .VRAM_data_out(VRAM_data_out),
    .render_active(render_active), .mirror_v(mirror_v), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata)
  );
  always #5 clk = ~clk;
  localparam logic [1:0] K_W = 2'd0, K_R = 2'd1, K_RR = 2'd2, K_RN = 2'd3;
  typedef struct {
    logic [1:0]  kind;
    logic        mv;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [27];
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cpu_op(input logic we, input logic [13:0] a, input logic [7:0] wd, output logic [7:0] rd);
    logic got;
    @(negedge clk);
    cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    got = 1'b0;
    rd = 8'h00;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin got = 1'b1; rd = cpu_rdata; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL cpu_timeout: addr %h got no ack expected ack", a);
    end
    @(negedge clk);
    cpu_req = 1'b0;
  endtask
  task automatic render_rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    VRAM_addr = a;
    @(posedge clk);
    @(posedge clk); #1;
    d = VRAM_data_out;
  endtask
  initial begin
    logic [7:0] d;
    int acks, cyc;
    logic got;
    vecs = '{
      '{K_W,  1'b1, 16'h2405, 8'h00, 8'h00},
      '{K_W,  1'b1, 16'h2005, 8'hAB, 8'h00},
      '{K_RR, 1'b1, 16'h2805, 8'h00, 8'hAB},
      '{K_RN, 1'b1, 16'h2405, 8'h00, 8'hAB},
      '{K_RR, 1'b0, 16'h2405, 8'h00, 8'hAB},
      '{K_RR, 1'b0, 16'h3005, 8'h00, 8'hAB},
      '{K_W,  1'b0, 16'h2000, 8'h11, 8'h00},
      '{K_W,  1'b0, 16'h2001, 8'h22, 8'h00},
      '{K_R,  1'b0, 16'h2000, 8'h00, 8'h00},
      '{K_R,  1'b0, 16'h2001, 8'h00, 8'h11},
      '{K_R,  1'b0, 16'h2001, 8'h00, 8'h22},
      '{K_W,  1'b0, 16'h2F00, 8'h77, 8'h00},
      '{K_W,  1'b0, 16'h2F01, 8'h66, 8'h00},
      '{K_W,  1'b0, 16'h3F10, 8'h3F, 8'h00},
      '{K_R,  1'b0, 16'h3F00, 8'h00, 8'h3F},
      '{K_R,  1'b0, 16'h2000, 8'h00, 8'h77},
      '{K_W,  1'b0, 16'h3F01, 8'hFF, 8'h00},
      '{K_R,  1'b0, 16'h3F01, 8'h00, 8'h3F},
      '{K_R,  1'b0, 16'h2001, 8'h00, 8'h66},
      '{K_W,  1'b0, 16'h3F04, 8'h25, 8'h00},
      '{K_RR, 1'b0, 16'h3F14, 8'h00, 8'h25},
      '{K_RR, 1'b0, 16'h3F10, 8'h00, 8'h3F},
      '{K_W,  1'b0, 16'h1053, 8'h5A, 8'h00},
      '{K_RR, 1'b0, 16'h1053, 8'h00, 8'h5A},
      '{K_RR, 1'b0, 16'h5053, 8'h00, 8'h5A},
      '{K_R,  1'b0, 16'h1053, 8'h00, 8'h22},
      '{K_R,  1'b0, 16'h1053, 8'h00, 8'h5A}
    };
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {7'h00, cpu_ack}, 8'h00);
    check("reset_rdata", cpu_rdata, 8'h00);
    check("reset_vram", VRAM_data_out, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 27; i++) begin
      mirror_v = vecs[i].mv;
      if (vecs[i].kind == K_W) cpu_op(1'b1, vecs[i].addr[13:0], vecs[i].data, d);
      else if (vecs[i].kind == K_R) begin
        cpu_op(1'b0, vecs[i].addr[13:0], 8'h00, d);
        check($sformatf("vec%0d_cpu_rd_%h", i, vecs[i].addr), d, vecs[i].exp);
      end else begin
        render_rd(vecs[i].addr, d);
        if (vecs[i].kind == K_RR) check($sformatf("vec%0d_render_%h", i, vecs[i].addr), d, vecs[i].exp);
        else begin
          n_chk++;
          if (d === vecs[i].exp) begin
            n_fail++;
            $display("FAIL vec%0d_render_ne_%h: got %h expected not %h", i, vecs[i].addr, d, vecs[i].exp);
          end
        end
      end
    end
    cpu_op(1'b1, 14'h0007, 8'h00, d);
    @(negedge clk);
    render_active = 1'b1;
    VRAM_addr = 16'h0007;
    cpu_we = 1'b1; cpu_addr = 14'h0007; cpu_wdata = 8'hC3; cpu_req = 1'b1;
    acks = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (cpu_ack) acks++;
    end
    check("stall_no_ack", 8'(acks), 8'h00);
    check("stall_chr_unchanged", VRAM_data_out, 8'h00);
    @(negedge clk);
    render_active = 1'b0;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ack) got = 1'b1;
    end
    check("stall_ack_latency", 8'(cyc), 8'd2);
    @(negedge clk);
    cpu_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("stall_write_landed", VRAM_data_out, 8'hC3);
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 14'h2000; cpu_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    render_active = 1'b1;
    @(posedge clk); #1;
    check("mid_access_ack", {7'h00, cpu_ack}, 8'h01);
    check("mid_access_rdata", cpu_rdata, 8'h5A);
    @(negedge clk);
    cpu_req = 1'b0;
    render_active = 1'b0;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 14'h2001; cpu_req = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_ack", {7'h00, cpu_ack}, 8'h00);
    check("rst_mid_rdata", cpu_rdata, 8'h00);
    check("rst_mid_vram", VRAM_data_out, 8'h00);
    cpu_req = 1'b0;
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (cpu_ack) acks++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (cpu_ack) acks++;
    end
    check("rst_no_ack", 8'(acks), 8'h00);
    mirror_v = 1'b0;
    render_rd(16'h2000, d);
    check("rst_keep_nt", d, 8'h11);
    render_rd(16'h1053, d);
    check("rst_keep_chr", d, 8'h5A);
    cpu_op(1'b0, 14'h2000, 8'h00, d);
    check("rst_buf_cleared", d, 8'h00);
    cpu_op(1'b0, 14'h2000, 8'h00, d);
    check("rst_buf_reload", d, 8'h11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
